// File: rtl/lcd_bus_decoder.sv
// HD44780-style responder for the 6-bit character-LCD bus: decodes E strobes into
// nibbles and bytes, tracks the DDRAM address, mirrors a 2x16 display and flags protocol errors.
module lcd_bus_decoder #(
    parameter int         BUSY_CYCLES = 40,
    parameter logic [7:0] CLR_CHAR    = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] lcd,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_rs,
    output logic       mode4,
    output logic [6:0] ddram_addr,
    output logic       busy,
    output logic       err
);
    typedef enum logic [1:0] {INIT8, NIB_HI, NIB_LO, SWEEP} state_t;

    state_t      state_reg;
    state_t      ret_reg;
    logic [5:0]  lcd_q;
    logic        strobe;
    logic        s_rs;
    logic [3:0]  s_nib;
    logic [3:0]  hi_reg;
    logic        hi_rs_reg;
    logic        dec_reg;
    logic        id_reg;
    logic        start_reg;
    logic [4:0]  sweep_idx_reg;
    logic [15:0] busy_cnt_reg;
    logic [7:0]  hl_byte;

    logic [7:0]  mem [0:31];
    logic        mem_we;
    logic [4:0]  mem_wa;
    logic [7:0]  mem_wd;

    function automatic logic [6:0] step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h0F)      r = 7'h40;
            else if (a == 7'h4F) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h4F;
            else if (a == 7'h40) r = 7'h0F;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    assign strobe  = lcd_q[5] & ~lcd[5];
    assign s_rs    = lcd_q[4];
    assign s_nib   = lcd_q[3:0];
    assign hl_byte = {hi_reg, s_nib};
    assign busy    = (state_reg == SWEEP) || (busy_cnt_reg != 16'd0);

    // Sweep and data writes never coincide: a byte is only pending outside a sweep.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = {ddram_addr[6], ddram_addr[3:0]};
        mem_wd = byte_out;
        if (state_reg == SWEEP) begin
            mem_we = 1'b1;
            mem_wa = sweep_idx_reg;
            mem_wd = CLR_CHAR;
        end else if (byte_valid && dec_reg && byte_rs) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= 8'h00;
        else
            rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_q         <= 6'd0;
            state_reg     <= INIT8;
            ret_reg       <= INIT8;
            hi_reg        <= 4'd0;
            hi_rs_reg     <= 1'b0;
            byte_valid    <= 1'b0;
            byte_out      <= 8'h00;
            byte_rs       <= 1'b0;
            dec_reg       <= 1'b0;
            mode4         <= 1'b0;
            ddram_addr    <= 7'h00;
            id_reg        <= 1'b1;
            err           <= 1'b0;
            start_reg     <= 1'b1;
            sweep_idx_reg <= 5'd0;
            busy_cnt_reg  <= 16'd0;
        end else begin
            lcd_q      <= lcd;
            byte_valid <= 1'b0;
            dec_reg    <= 1'b0;
            start_reg  <= 1'b0;
            if (busy_cnt_reg != 16'd0)
                busy_cnt_reg <= busy_cnt_reg - 16'd1;
            if (strobe && busy)
                err <= 1'b1;

            if (start_reg) begin
                state_reg     <= SWEEP;
                sweep_idx_reg <= 5'd0;
            end else begin
                case (state_reg)
                    INIT8: if (strobe) begin
                        byte_valid   <= 1'b1;
                        byte_out     <= {s_nib, 4'h0};
                        byte_rs      <= s_rs;
                        busy_cnt_reg <= 16'(BUSY_CYCLES);
                        if (s_nib == 4'h2) begin
                            mode4     <= 1'b1;
                            state_reg <= NIB_HI;
                        end else if (s_nib != 4'h3) begin
                            err <= 1'b1;
                        end
                    end
                    NIB_HI: if (strobe) begin
                        hi_reg    <= s_nib;
                        hi_rs_reg <= s_rs;
                        state_reg <= NIB_LO;
                    end
                    NIB_LO: if (strobe) begin
                        byte_valid <= 1'b1;
                        byte_out   <= hl_byte;
                        byte_rs    <= hi_rs_reg;
                        dec_reg    <= 1'b1;
                        if (s_rs != hi_rs_reg)
                            err <= 1'b1;
                        // Clear starts its sweep immediately so busy covers N+1..N+32.
                        if (!hi_rs_reg && hl_byte == 8'h01) begin
                            state_reg     <= SWEEP;
                            ret_reg       <= NIB_HI;
                            sweep_idx_reg <= 5'd0;
                        end else begin
                            state_reg    <= NIB_HI;
                            busy_cnt_reg <= 16'(BUSY_CYCLES);
                        end
                    end
                    SWEEP: begin
                        sweep_idx_reg <= sweep_idx_reg + 5'd1;
                        if (sweep_idx_reg == 5'd31)
                            state_reg <= ret_reg;
                    end
                    default: state_reg <= INIT8;
                endcase
            end

            if (byte_valid && dec_reg) begin
                if (byte_rs) begin
                    ddram_addr <= step(ddram_addr, id_reg);
                end else if (byte_out == 8'h01) begin
                    ddram_addr <= 7'h00;
                    id_reg     <= 1'b1;
                end else if (byte_out == 8'h02 || byte_out == 8'h03) begin
                    ddram_addr <= 7'h00;
                end else if (byte_out[7:2] == 6'b000001) begin
                    id_reg <= byte_out[1];
                end else if (byte_out[7]) begin
                    if (byte_out[6:4] == 3'b000 || byte_out[6:4] == 3'b100)
                        ddram_addr <= byte_out[6:0];
                    else
                        err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Scoreboard bench for lcd_bus_decoder: directed bus traffic, expected bytes queued
// at issue time and checked by an independent monitor on byte_valid.
module tb_lcd_bus_decoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] lcd = 6'd0;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       byte_rs;
    logic       mode4;
    logic [6:0] ddram_addr;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    lcd_bus_decoder #(.BUSY_CYCLES(40), .CLR_CHAR(8'h20)) dut (
        .clk(clk), .reset(reset), .lcd(lcd), .rd_addr(rd_addr), .rd_data(rd_data),
        .byte_valid(byte_valid), .byte_out(byte_out), .byte_rs(byte_rs), .mode4(mode4),
        .ddram_addr(ddram_addr), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every decoded byte must match the head of the scoreboard.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (byte_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %02h rs %0d expected none", byte_out, byte_rs);
                end else begin
                    e = exp_q.pop_front();
                    if ({byte_out, byte_rs} !== e) begin
                        errors++;
                        $display("FAIL byte: got %02h rs %0d expected %02h rs %0d",
                                 byte_out, byte_rs, e[8:1], e[0]);
                    end else begin
                        $display("byte %02h rs %0d ok", byte_out, byte_rs);
                    end
                end
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_nib(input logic rs, input logic [3:0] nib);
        lcd = {1'b1, rs, nib};
        @(negedge clk);
        lcd = {1'b0, rs, nib};
        @(negedge clk);
    endtask

    task automatic init_nib(input logic [3:0] nib);
        exp_q.push_back({nib, 4'h0, 1'b0});
        send_nib(1'b0, nib);
        gap(45);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, input int wait_n);
        exp_q.push_back({b, rs});
        send_nib(rs, b[7:4]);
        send_nib(rs, b[3:0]);
        gap(wait_n);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] idx, input logic [7:0] exp);
        rd_addr = idx;
        @(negedge clk);
        chk(name, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic busy_window(input string name);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) cnt++;
            @(negedge clk);
        end
        chk(name, cnt, 32);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        lcd = 6'd0;
        gap(3);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_byte_valid", {31'd0, byte_valid}, 0);
        chk("reset_ddram", {25'd0, ddram_addr}, 0);
        reset = 1'b0;
        busy_window("sweep_busy_cycles");
    endtask

    task automatic do_init();
        init_nib(4'h3);
        init_nib(4'h3);
        init_nib(4'h3);
        chk("mode4_before_2", {31'd0, mode4}, 0);
        init_nib(4'h2);
        chk("mode4_after_2", {31'd0, mode4}, 1);
        send_byte(1'b0, 8'h28, 45);
    endtask

    initial begin
        // Power-on sweep
        gap(2);
        chk("por_err", {31'd0, err}, 0);
        do_reset();
        for (int i = 0; i < 32; i++) rd_chk("sweep_fill", 5'(i), 8'h20);
        chk("sweep_err", {31'd0, err}, 0);
        chk("sweep_mode4", {31'd0, mode4}, 0);

        do_init();
        chk("init_err", {31'd0, err}, 0);

        // Plain writes from address 0
        send_byte(1'b0, 8'h80, 45);
        send_byte(1'b1, 8'h57, 45);
        send_byte(1'b1, 8'h42, 45);
        chk("addr_after_wb", {25'd0, ddram_addr}, 32'h02);
        rd_chk("mirror0", 5'd0, 8'h57);
        rd_chk("mirror1", 5'd1, 8'h42);

        // Line wrap forward and backward
        send_byte(1'b0, 8'h8F, 45);
        send_byte(1'b1, 8'h61, 45);
        send_byte(1'b1, 8'h62, 45);
        chk("addr_after_wrap", {25'd0, ddram_addr}, 32'h41);
        rd_chk("mirror15", 5'd15, 8'h61);
        rd_chk("mirror16", 5'd16, 8'h62);
        send_byte(1'b0, 8'h04, 45);
        send_byte(1'b1, 8'h63, 45);
        chk("addr_dec", {25'd0, ddram_addr}, 32'h40);
        rd_chk("mirror17", 5'd17, 8'h63);
        send_byte(1'b1, 8'h64, 45);
        chk("addr_dec_wrap", {25'd0, ddram_addr}, 32'h0F);
        rd_chk("mirror16_dec", 5'd16, 8'h64);
        send_byte(1'b0, 8'h06, 45);
        send_byte(1'b0, 8'hCF, 45);
        send_byte(1'b1, 8'h65, 45);
        chk("addr_4f_wrap", {25'd0, ddram_addr}, 32'h00);
        rd_chk("mirror31", 5'd31, 8'h65);
        chk("wrap_err", {31'd0, err}, 0);

        // Clear command
        send_byte(1'b0, 8'h01, 0);
        busy_window("clear_busy_cycles");
        chk("clear_addr", {25'd0, ddram_addr}, 0);
        rd_chk("clear_mirror15", 5'd15, 8'h20);
        rd_chk("clear_mirror31", 5'd31, 8'h20);
        chk("clear_err", {31'd0, err}, 0);

        // Strobe while busy
        send_byte(1'b0, 8'h06, 5);
        chk("pre_busy_err", {31'd0, err}, 0);
        send_byte(1'b0, 8'h06, 45);
        chk("busy_err", {31'd0, err}, 1);
        send_byte(1'b0, 8'h80, 45);
        chk("err_sticky", {31'd0, err}, 1);

        // RS mismatch between nibbles, then invalid address
        do_reset();
        chk("reset_clears_err", {31'd0, err}, 0);
        do_init();
        exp_q.push_back({8'h41, 1'b1});
        send_nib(1'b1, 4'h4);
        send_nib(1'b0, 4'h1);
        gap(45);
        chk("rs_mismatch_err", {31'd0, err}, 1);
        chk("rs_mismatch_addr", {25'd0, ddram_addr}, 32'h01);
        rd_chk("rs_mismatch_data", 5'd0, 8'h41);
        send_byte(1'b0, 8'hA0, 45);
        chk("bad_addr_unchanged", {25'd0, ddram_addr}, 32'h01);

        // Reset with a high nibble pending
        send_nib(1'b0, 4'h8);
        gap(2);
        do_reset();
        chk("midbyte_mode4", {31'd0, mode4}, 0);
        rd_chk("midbyte_mirror0", 5'd0, 8'h20);
        init_nib(4'h3);
        chk("back_in_init8_err", {31'd0, err}, 0);
        chk("back_in_init8_mode4", {31'd0, mode4}, 0);

        gap(3);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_bus_decoder.md
Name: lcd_bus_decoder

Overview:
- Receiving end of the 6-bit character-LCD bus driven by the chess timer's LCD controller. Behaves as an HD44780-style responder for simulation and on-board self-check.
- Decodes E strobes into nibbles, then into command/data bytes, and tracks the DDRAM address.
- Keeps a 2x16 character mirror that a checker or debug port can read back, and flags protocol violations.

Parameters:
- BUSY_CYCLES, 40, clk cycles the responder stays busy after each completed byte other than clear.
- CLR_CHAR, 8'h20, fill character written by clear and by the post-reset sweep.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- lcd  in  6  LCD bus: [5]=E, [4]=RS, [3:0]=D7..D4
- rd_addr  in  5  mirror read index: [4]=line, [3:0]=column
- rd_data  out  8  mirror character at rd_addr, 1-cycle latency
- byte_valid  out  1  one-cycle pulse when a byte is decoded
- byte_out  out  8  decoded byte, held until the next byte
- byte_rs  out  1  RS of the decoded byte
- mode4  out  1  1 once 4-bit mode is entered
- ddram_addr  out  7  current DDRAM address counter
- busy  out  1  responder busy (sweep or BUSY_CYCLES timer running)
- err  out  1  sticky protocol-error flag; cleared only by reset

Behaviour:
- Input sampling:
  - lcd is registered once into lcd_q every cycle.
  - A strobe is the cycle where lcd_q[5]=1 and lcd[5]=0 (falling edge of E).
  - RS and nibble are taken from lcd_q in that cycle.
- Reset values: all outputs 0; FSM=INIT8; entry direction I/D=1. On reset release a clear sweep starts at once.
- FSM states: INIT8, NIB_HI, NIB_LO, SWEEP.
- INIT8:
  - Each strobe forms the byte {nibble,4'h0} with byte_valid pulsed.
  - Nibble 4'h3 is accepted and changes nothing.
  - Nibble 4'h2 sets mode4=1 and moves to NIB_HI.
  - Any other nibble sets err and stays in INIT8.
- NIB_HI: a strobe latches the high nibble and RS, then moves to NIB_LO.
- NIB_LO:
  - A strobe completes byte={hi,lo}; moves to NIB_HI.
  - If RS differs from the high nibble's RS, set err; the byte is still emitted using the high nibble's RS.
- Decode timing: strobe in cycle N gives byte_valid=1 in cycle N+1. ddram_addr and the mirror reflect the byte from cycle N+2.
- Data byte (RS=1): write mirror[ddram_addr], then step ddram_addr by I/D.
- Command byte (RS=0), first match wins:
  - 8'h01: clear. ddram_addr=0, I/D=1, enter SWEEP.
  - 8'h02 or 8'h03: ddram_addr=0.
  - 8'h04..8'h07: I/D = bit1.
  - 8'h80..8'hFF: set ddram_addr = byte[6:0] if it is in 0x00..0x0F or 0x40..0x4F. Otherwise set err and leave the address unchanged.
  - 8'h20..8'h3F: function set, no effect.
  - Anything else is ignored without error.
- Address wrap:
  - Increment: 0x0F→0x40, 0x4F→0x00.
  - Decrement: 0x00→0x4F, 0x40→0x0F.
- Mirror index: {addr[6], addr[3:0]}.
- SWEEP: writes CLR_CHAR to one mirror entry per cycle, index 0..31; busy=1 for exactly 32 cycles, then returns to the state held before the sweep.
- Busy timer: after any non-clear byte, busy=1 for BUSY_CYCLES cycles starting at N+1.
- Strobe while busy=1: set err. The strobe is still decoded; a strobe during SWEEP is discarded apart from setting err.
- Reset mid-operation (any state, including mid-byte or mid-sweep):
  - Returns to INIT8 with mode4=0.
  - Partial nibble is discarded.
  - A fresh sweep starts.
- rd_data is registered: rd_addr in cycle K gives data in cycle K+1. A write and a read to the same index in the same cycle return the old value.

Test Plan:
- Reset, then hold lcd=0 for 40 cycles → busy=1 for cycles 1..32 after release; all 32 rd_data reads = 8'h20; err=0, mode4=0.
- Nibble strobes 3,3,3,2 (RS=0), then byte 8'h28 as 2 then 8 → byte_valid pulses 5 times; mode4=1 after the 4th strobe; byte_out=8'h28; err=0.
- After init: 8'h80, then data 'W'(8'h57), 'B'(8'h42), with strobes spaced past BUSY_CYCLES → mirror[0]=8'h57, mirror[1]=8'h42, ddram_addr=7'h02.
- Set addr 8'h8F, write two chars → first char at index 15, second at index 16 (addr 0x40), final ddram_addr=7'h41. Then 8'h04 and write one char → char at 0x41, ddram_addr=7'h40.
- Strobe a byte 5 cycles after the previous one (busy) → err=1 and stays 1 through later legal traffic until reset.
- High nibble with RS=1, low nibble with RS=0 → err=1, byte_rs=1. Then command 8'hA0 → err already set, ddram_addr unchanged. Reset mid-NIB_LO → mode4=0, state INIT8, sweep runs 32 cycles.
